// File: rtl/ptf_pixel_writer.sv
// Projective-transform pixel writer: merges pixel pairs into ZBT words,
// queues them in a small FIFO and writes a double-buffered frame store.
module ptf_pixel_writer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int H_PIXELS       = 640,
  parameter int V_PIXELS       = 480,
  parameter int WORDS_PER_LINE = 320
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] pixel,
  input  logic [9:0]  pixel_x,
  input  logic [8:0]  pixel_y,
  input  logic        pixel_flag,
  input  logic        frame_flag,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic [18:0] mem_addr,
  output logic [35:0] mem_data,
  output logic [3:0]  mem_bwe,
  output logic        display_bank,
  output logic        overflow,
  output logic        dropped
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 59;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [10:0] HMAX  = 11'(H_PIXELS);
  localparam logic [9:0]  VMAX  = 10'(V_PIXELS);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]  state;
  logic        bank;

  logic        held_valid;
  logic [18:0] held_addr;
  logic [35:0] held_data;
  logic [3:0]  held_bwe;

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic        in_range;
  logic        pix_ok;
  logic [17:0] y18;
  logic [17:0] x_word;
  logic [17:0] line_base;
  logic [18:0] pix_addr;
  logic [3:0]  pix_bwe;
  logic [35:0] pix_data;
  logic [35:0] merge_data;
  logic        addr_hit;
  logic        held_full;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_wr;
  logic [EW-1:0] head;

  assign in_range = ({1'b0, pixel_x} < HMAX) &&
                    ({1'b0, pixel_y} < VMAX);
  assign pix_ok   = pixel_flag & in_range;

  assign y18    = {9'b0, pixel_y};
  assign x_word = {9'b0, pixel_x[9:1]};

  generate
    if (WORDS_PER_LINE == 320) begin : g_shift
      assign line_base = (y18 << 8) + (y18 << 6);
    end else begin : g_mul
      assign line_base = y18 * 18'(WORDS_PER_LINE);
    end
  endgenerate

  assign pix_addr = {bank, line_base + x_word};
  assign pix_bwe  = pixel_x[0] ? 4'b0011 : 4'b1100;
  assign pix_data = pixel_x[0] ? {18'b0, pixel}
                               : {pixel, 18'b0};
  assign merge_data = pixel_x[0] ? {held_data[35:18], pixel}
                                 : {pixel, held_data[17:0]};

  assign addr_hit  = held_valid && (held_addr == pix_addr);
  assign held_full = (held_bwe == 4'b1111);

  // Merging only spans back-to-back strobes; a full word leaves at once.
  assign push = held_valid &
                (held_full | ~pixel_flag | (pix_ok & ~addr_hit));

  assign mem_req   = (count != '0);
  assign pop       = mem_grant & mem_req;
  assign fifo_full = (count == DEPTH);
  assign fifo_wr   = push & (~fifo_full | pop);

  assign head     = fifo_mem[rd_ptr];
  assign mem_addr = mem_req ? head[58:40] : '0;
  assign mem_data = mem_req ? head[39:4]  : '0;
  assign mem_bwe  = mem_req ? head[3:0]   : '0;

  assign display_bank = ~bank;

  always_ff @(posedge clk) begin
    if (reset) begin
      held_valid <= 1'b0;
      held_addr  <= '0;
      held_data  <= '0;
      held_bwe   <= '0;
    end else if (pix_ok && held_valid && !push) begin
      held_data <= merge_data;
      held_bwe  <= held_bwe | pix_bwe;
    end else if (pix_ok) begin
      held_valid <= 1'b1;
      held_addr  <= pix_addr;
      held_data  <= pix_data;
      held_bwe   <= pix_bwe;
    end else if (push) begin
      held_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr] <= {held_addr, held_data, held_bwe};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      unique case ({fifo_wr, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) dropped <= 1'b0;
    else       dropped <= pixel_flag & ~in_range;
  end

  // Bank swaps only once everything written to the old bank has left.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      bank  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (frame_flag) state <= FLUSH;
        end
        FLUSH: begin
          if (count == '0 && !held_valid && !pix_ok) begin
            bank  <= ~bank;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ptf_pixel_writer.sv
// Directed scoreboard bench for ptf_pixel_writer.
// Expected words are queued at stimulus time, checked on each granted write.
module tb_ptf_pixel_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] pixel;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        pixel_flag;
  logic        frame_flag;
  logic        mem_req;
  logic        mem_grant;
  logic [18:0] mem_addr;
  logic [35:0] mem_data;
  logic [3:0]  mem_bwe;
  logic        display_bank;
  logic        overflow;
  logic        dropped;

  typedef struct {
    logic [18:0] a;
    logic [35:0] d;
    logic [3:0]  b;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_writes = 0;
  logic tb_bank = 1'b0;

  ptf_pixel_writer dut (
    .clk(clk), .reset(reset),
    .pixel(pixel), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_flag(pixel_flag), .frame_flag(frame_flag),
    .mem_req(mem_req), .mem_grant(mem_grant),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_bwe(mem_bwe),
    .display_bank(display_bank), .overflow(overflow),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] waddr(input logic bk,
                                        input int x, input int y);
    int w;
    w = y * 320 + x / 2;
    return {bk, w[17:0]};
  endfunction

  task automatic expect_word(input int x0, input int y,
                             input logic [17:0] p0, input bit h0,
                             input logic [17:0] p1, input bit h1);
    exp_t e;
    e.a = waddr(tb_bank, x0, y);
    e.d = {h0 ? p0 : 18'b0, h1 ? p1 : 18'b0};
    e.b = {h0, h0, h1, h1};
    sb.push_back(e);
  endtask

  // One clock: drive inputs, score any granted write, wait for negedge.
  task automatic step(input bit pf, input int x, input int y,
                      input logic [17:0] p, input bit ff,
                      input bit g, input bit rst = 1'b0);
    exp_t e;
    logic [35:0] m;
    reset      = rst;
    pixel_flag = pf;
    pixel_x    = 10'(x);
    pixel_y    = 9'(y);
    pixel      = p;
    frame_flag = ff;
    mem_grant  = g;
    #1;
    if (mem_req && mem_grant) begin
      n_writes++;
      n_cmp++;
      assert (sb.size() > 0) else begin
        n_bad++;
        $error("FAIL unexp_write: observed addr %0h expected none",
               mem_addr);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        m = {{18{e.b[3]}}, {18{e.b[1]}}};
        chk("wr_addr", 64'(mem_addr), 64'(e.a));
        chk("wr_data", 64'(mem_data & m), 64'(e.d & m));
        chk("wr_bwe", 64'(mem_bwe), 64'(e.b));
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit g);
    step(1'b0, 0, 0, 18'h0, 1'b0, g);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (sb.size() != 0 || mem_req); i++)
      idle(1'b1);
    chk("drain_sb", 64'(sb.size()), 64'd0);
    chk("drain_req", 64'(mem_req), 64'd0);
  endtask

  initial begin
    step(1'b0, 0, 0, 18'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 18'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(dropped), 64'd0);
    chk("rst_disp", 64'(display_bank), 64'd1);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_data", 64'(mem_data), 64'd0);
    chk("rst_bwe", 64'(mem_bwe), 64'd0);

    // Sequential pair merges into one full word (N+3 latency)
    expect_word(4, 0, 18'h2aaaa, 1'b1, 18'h15555, 1'b1);
    step(1'b1, 4, 0, 18'h2aaaa, 1'b0, 1'b1);
    step(1'b1, 5, 0, 18'h15555, 1'b0, 1'b1);
    chk("pair_lat_n2", 64'(mem_req), 64'd0);
    idle(1'b1);
    chk("pair_lat_n3", 64'(mem_req), 64'd1);
    chk("pair_addr_lit", 64'(mem_addr), 64'h2);
    drain();

    // Isolated odd pixel (N+2 latency)
    expect_word(7, 2, 18'h0, 1'b0, 18'h3c3c3, 1'b1);
    step(1'b1, 7, 2, 18'h3c3c3, 1'b0, 1'b1);
    chk("odd_lat_n1", 64'(mem_req), 64'd0);
    idle(1'b1);
    chk("odd_lat_n2", 64'(mem_req), 64'd1);
    chk("odd_addr_lit", 64'(mem_addr), 64'd643);
    drain();

    // Out-of-range pixels
    step(1'b1, 640, 10, 18'h11111, 1'b0, 1'b1);
    chk("drop_x_pulse", 64'(dropped), 64'd1);
    idle(1'b1);
    chk("drop_x_clear", 64'(dropped), 64'd0);
    chk("drop_x_noreq", 64'(mem_req), 64'd0);
    step(1'b1, 0, 480, 18'h22222, 1'b0, 1'b1);
    chk("drop_y_pulse", 64'(dropped), 64'd1);
    idle(1'b1);
    chk("drop_y_noreq", 64'(mem_req), 64'd0);
    expect_word(639, 479, 18'h0, 1'b0, 18'h0abcd, 1'b1);
    step(1'b1, 639, 479, 18'h0abcd, 1'b0, 1'b1);
    chk("max_nodrop", 64'(dropped), 64'd0);
    idle(1'b1);
    chk("max_addr_lit", 64'(mem_addr), 64'd153599);
    drain();

    // Backpressure: nine words into an eight-entry FIFO
    for (int k = 0; k < 9; k++) begin
      if (k < 8) expect_word(2 * k, 1, 18'(256 + k), 1'b1, 18'h0, 1'b0);
      if (k == 8) chk("bp_ovf_before", 64'(overflow), 64'd0);
      step(1'b1, 2 * k, 1, 18'(256 + k), 1'b0, 1'b0);
      idle(1'b0);
    end
    chk("bp_ovf_after", 64'(overflow), 64'd1);
    chk("bp_head_addr", 64'(mem_addr), 64'd320);
    n_writes = 0;
    for (int k = 0; k < 8; k++) idle(1'b1);
    chk("bp_writes", 64'(n_writes), 64'd8);
    chk("bp_req_fall", 64'(mem_req), 64'd0);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);
    chk("bp_ovf_sticky", 64'(overflow), 64'd1);

    // Frame swap waits for the old bank to flush
    expect_word(0, 0, 18'h1d1d1, 1'b1, 18'h0, 1'b0);
    step(1'b1, 0, 0, 18'h1d1d1, 1'b0, 1'b0);
    step(1'b0, 0, 0, 18'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) idle(1'b0);
    chk("fs_disp_hold", 64'(display_bank), 64'd1);
    chk("fs_req_held", 64'(mem_req), 64'd1);
    for (int k = 0; k < 6 && display_bank != 1'b0; k++) idle(1'b1);
    chk("fs_disp_swap", 64'(display_bank), 64'd0);
    chk("fs_sb_empty", 64'(sb.size()), 64'd0);
    tb_bank = 1'b1;
    expect_word(2, 0, 18'h2e2e2, 1'b1, 18'h0, 1'b0);
    step(1'b1, 2, 0, 18'h2e2e2, 1'b0, 1'b0);
    idle(1'b0);
    chk("fs_bank1_addr", 64'(mem_addr), 64'h40001);
    drain();

    // Reset with three words queued
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 2 * k, 5, 18'(k + 1), 1'b0, 1'b0);
      idle(1'b0);
    end
    chk("rs_req_before", 64'(mem_req), 64'd1);
    step(1'b0, 0, 0, 18'h0, 1'b0, 1'b0, 1'b1);
    sb.delete();
    tb_bank = 1'b0;
    chk("rs_req", 64'(mem_req), 64'd0);
    chk("rs_ovf", 64'(overflow), 64'd0);
    chk("rs_disp", 64'(display_bank), 64'd1);
    n_writes = 0;
    for (int k = 0; k < 3; k++) idle(1'b1);
    chk("rs_no_writes", 64'(n_writes), 64'd0);
    expect_word(4, 0, 18'h00f0f, 1'b1, 18'h0, 1'b0);
    step(1'b1, 4, 0, 18'h00f0f, 1'b0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
